// File: rtl/sevenseg_pkg.sv
// Shared constants and the hex-to-segment lookup for the seven-segment scanner.
// Segment vectors are ordered gfedcba, active-high.
package sevenseg_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   localparam seg_t SEG_TABLE [16] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1101111,  // 9
      7'b1110111,  // A
      7'b1111100,  // b
      7'b0111001,  // C
      7'b1011110,  // d
      7'b1111001,  // E
      7'b1110001   // F
   };

   function automatic seg_t hex_to_seg(input nibble_t nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational nibble-to-segment decoder (gfedcba, active-high).
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-cathode seven-segment driver with shadowed data, leading-zero
// suppression, per-digit dp/blanking, PWM brightness and a frame-done pulse.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DIV_BITS    = 16,
   parameter int BRIGHT_BITS = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [4*DIGITS-1:0]    datain,
   input  logic [DIGITS-1:0]      dp_in,
   input  logic [DIGITS-1:0]      blank_in,
   input  logic                   lz_en,
   input  logic                   load,
   input  logic [BRIGHT_BITS-1:0] brightness,
   output logic [DIGITS-1:0]      grounds,
   output logic [6:0]             display,
   output logic                   dp,
   output logic                   frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   logic [DIV_BITS-1:0]    presc_q, presc_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0]    data_q, data_d;
   logic [DIGITS-1:0]      dp_sh_q, dp_sh_d;
   logic [DIGITS-1:0]      blank_sh_q, blank_sh_d;
   logic                   lz_sh_q, lz_sh_d;
   logic [DIGITS-1:0]      grounds_q, grounds_d;
   logic [6:0]             display_q, display_d;
   logic                   dp_q, dp_d;
   logic                   frame_done_q, frame_done_d;

   logic                   tick;
   logic [DIGITS-1:0]      suppress;
   logic                   zero_run;
   logic [3:0]             cur_nibble;
   logic                   cur_dp;
   logic                   cur_blank;
   logic                   cur_supp;
   logic [6:0]             cur_seg;
   logic [BRIGHT_BITS-1:0] duty;
   logic                   lit;

   // Prescaler, digit index and shadow capture; load and tick act independently.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      tick       = &presc_q;
      presc_d    = presc_q + 1'b1;
      idx_d      = idx_q;
      data_d     = data_q;
      dp_sh_d    = dp_sh_q;
      blank_sh_d = blank_sh_q;
      lz_sh_d    = lz_sh_q;
      if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      if (load) begin
         data_d     = datain;
         dp_sh_d    = dp_in;
         blank_sh_d = blank_in;
         lz_sh_d    = lz_en;
      end
   end

   // A digit is suppressed while it and every more-significant nibble are zero.
   always_comb begin
      zero_run = lz_sh_q;
      suppress = '0;
      for (int i = 0; i < DIGITS; i++) begin
         zero_run    = zero_run && (data_q[4*(DIGITS-i)-1 -: 4] == 4'h0);
         suppress[i] = zero_run && (i != DIGITS - 1);
      end
   end

   always_comb begin
      cur_nibble = '0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_supp   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nibble = data_q[4*(DIGITS-i)-1 -: 4];
            cur_dp     = dp_sh_q[i];
            cur_blank  = blank_sh_q[i];
            cur_supp   = suppress[i];
         end
      end
   end

   sevenseg_decode u_decode (
      .nibble (cur_nibble),
      .seg    (cur_seg)
   );

   // Brightness is compared live against the top prescaler bits; all-ones never blinks.
   always_comb begin
      duty = presc_q[DIV_BITS-1 -: BRIGHT_BITS];
      lit  = !cur_blank && ((&brightness) || (duty < brightness));
   end

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         grounds_d[i] = !(lit && (idx_q == IDX_W'(i)));
      end
      display_d    = (lit && !cur_supp) ? cur_seg : SEG_BLANK;
      dp_d         = lit && cur_dp;
      frame_done_d = tick && (idx_q == LAST_IDX);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         data_q       <= '0;
         dp_sh_q      <= '0;
         blank_sh_q   <= '0;
         lz_sh_q      <= 1'b0;
         grounds_q    <= '1;
         display_q    <= SEG_BLANK;
         dp_q         <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         dp_sh_q      <= dp_sh_d;
         blank_sh_q   <= blank_sh_d;
         lz_sh_q      <= lz_sh_d;
         grounds_q    <= grounds_d;
         display_q    <= display_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign grounds    = grounds_q;
   assign display    = display_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan at DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2
// (16-clock slots, 64-clock frames).
module tb_sevenseg_scan;

   logic        clk;
   logic        reset_n;
   logic [15:0] datain;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_en;
   logic        load;
   logic [1:0]  brightness;
   logic [3:0]  grounds;
   logic [6:0]  display;
   logic        dp;
   logic        frame_done;

   sevenseg_scan #(
      .DIGITS      (4),
      .DIV_BITS    (4),
      .BRIGHT_BITS (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .datain     (datain),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .lz_en      (lz_en),
      .load       (load),
      .brightness (brightness),
      .grounds    (grounds),
      .display    (display),
      .dp         (dp),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic [3:0]  dpv;
      logic [3:0]  blank;
      logic        lz;
      logic [1:0]  bright;
      int          digit;
      int          presc;
      logic [3:0]  exp_g;
      logic [6:0]  exp_seg;
      logic        exp_dp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   // Edges since reset release; output after edge k reflects scan phase (k-1) mod 64.
   int   cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Advance until the outputs show the given digit slot and prescaler phase.
   task automatic wait_slot(input int digit, input int presc);
      int target;
      target = digit * 16 + presc;
      do step(); while (((cyc - 1) % 64) != target);
   endtask

   task automatic apply_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                             input logic lz, input logic [1:0] br);
      datain     = d;
      dp_in      = dpv;
      blank_in   = bl;
      lz_en      = lz;
      brightness = br;
      load       = 1'b1;
      step();
      load       = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   function automatic vec_t mk(input string name, input logic [15:0] data, input logic [3:0] dpv,
                               input logic [3:0] blank, input logic lz, input logic [1:0] bright,
                               input int digit, input int presc, input logic [3:0] exp_g,
                               input logic [6:0] exp_seg, input logic exp_dp);
      vec_t v;
      v.name = name; v.data = data; v.dpv = dpv; v.blank = blank; v.lz = lz;
      v.bright = bright; v.digit = digit; v.presc = presc;
      v.exp_g = exp_g; v.exp_seg = exp_seg; v.exp_dp = exp_dp;
      return v;
   endfunction

   initial begin
      int last_pulse;
      int pulses;
      int lit_cnt;

      reset_n    = 1'b0;
      datain     = '0;
      dp_in      = '0;
      blank_in   = '0;
      lz_en      = 1'b0;
      load       = 1'b0;
      brightness = 2'd3;

      //               name        data     dp      blank   lz br dig p  grounds  segs        dp
      vecs.push_back(mk("scan_d0", 16'h12A0, 4'b0000, 4'b0000, 0, 3, 0, 8, 4'b1110, 7'b0000110, 0));
      vecs.push_back(mk("scan_d1", 16'h12A0, 4'b0000, 4'b0000, 0, 3, 1, 8, 4'b1101, 7'b1011011, 0));
      vecs.push_back(mk("scan_d2", 16'h12A0, 4'b0000, 4'b0000, 0, 3, 2, 8, 4'b1011, 7'b1110111, 0));
      vecs.push_back(mk("scan_d3", 16'h12A0, 4'b0000, 4'b0000, 0, 3, 3, 8, 4'b0111, 7'b0111111, 0));
      vecs.push_back(mk("hex_8",   16'h8BEF, 4'b0000, 4'b0000, 0, 3, 0, 2, 4'b1110, 7'b1111111, 0));
      vecs.push_back(mk("hex_b",   16'h8BEF, 4'b0000, 4'b0000, 0, 3, 1, 2, 4'b1101, 7'b1111100, 0));
      vecs.push_back(mk("hex_E",   16'h8BEF, 4'b0000, 4'b0000, 0, 3, 2, 2, 4'b1011, 7'b1111001, 0));
      vecs.push_back(mk("hex_F",   16'h8BEF, 4'b0000, 4'b0000, 0, 3, 3, 2, 4'b0111, 7'b1110001, 0));
      vecs.push_back(mk("hex_3",   16'h3679, 4'b0000, 4'b0000, 0, 3, 0, 15, 4'b1110, 7'b1001111, 0));
      vecs.push_back(mk("hex_6",   16'h3679, 4'b0000, 4'b0000, 0, 3, 1, 0, 4'b1101, 7'b1111101, 0));
      vecs.push_back(mk("hex_7",   16'h3679, 4'b0000, 4'b0000, 0, 3, 2, 5, 4'b1011, 7'b0000111, 0));
      vecs.push_back(mk("hex_9",   16'h3679, 4'b0000, 4'b0000, 0, 3, 3, 11, 4'b0111, 7'b1101111, 0));
      vecs.push_back(mk("lz5_d0",  16'h0005, 4'b0000, 4'b0000, 1, 3, 0, 8, 4'b1110, 7'b0000000, 0));
      vecs.push_back(mk("lz5_d1",  16'h0005, 4'b0000, 4'b0000, 1, 3, 1, 8, 4'b1101, 7'b0000000, 0));
      vecs.push_back(mk("lz5_d2",  16'h0005, 4'b0000, 4'b0000, 1, 3, 2, 8, 4'b1011, 7'b0000000, 0));
      vecs.push_back(mk("lz5_d3",  16'h0005, 4'b0000, 4'b0000, 1, 3, 3, 8, 4'b0111, 7'b1101101, 0));
      vecs.push_back(mk("lz0_d3",  16'h0000, 4'b0000, 4'b0000, 1, 3, 3, 8, 4'b0111, 7'b0111111, 0));
      vecs.push_back(mk("lz0_d2",  16'h0000, 4'b0000, 4'b0000, 1, 3, 2, 8, 4'b1011, 7'b0000000, 0));
      vecs.push_back(mk("lz30_d1", 16'h0030, 4'b0000, 4'b0000, 1, 3, 1, 8, 4'b1101, 7'b0000000, 0));
      vecs.push_back(mk("lz30_d2", 16'h0030, 4'b0000, 4'b0000, 1, 3, 2, 8, 4'b1011, 7'b1001111, 0));
      vecs.push_back(mk("lz30_d3", 16'h0030, 4'b0000, 4'b0000, 1, 3, 3, 8, 4'b0111, 7'b0111111, 0));
      vecs.push_back(mk("lzoff",   16'h0005, 4'b0000, 4'b0000, 0, 3, 0, 8, 4'b1110, 7'b0111111, 0));
      vecs.push_back(mk("lz_dp",   16'h0005, 4'b0001, 4'b0000, 1, 3, 0, 8, 4'b1110, 7'b0000000, 1));
      vecs.push_back(mk("blank_d2", 16'h12A0, 4'b0010, 4'b0100, 0, 3, 2, 8, 4'b1111, 7'b0000000, 0));
      vecs.push_back(mk("dp_d1",   16'h12A0, 4'b0010, 4'b0100, 0, 3, 1, 8, 4'b1101, 7'b1011011, 1));
      vecs.push_back(mk("dp_d0",   16'h12A0, 4'b0010, 4'b0100, 0, 3, 0, 8, 4'b1110, 7'b0000110, 0));
      vecs.push_back(mk("blank_all", 16'h12A0, 4'b1111, 4'b1111, 0, 3, 3, 8, 4'b1111, 7'b0000000, 0));
      vecs.push_back(mk("pwm1_on", 16'h12A0, 4'b0010, 4'b0000, 0, 1, 1, 3, 4'b1101, 7'b1011011, 1));
      vecs.push_back(mk("pwm1_off", 16'h12A0, 4'b0010, 4'b0000, 0, 1, 1, 4, 4'b1111, 7'b0000000, 0));
      vecs.push_back(mk("pwm2_on", 16'h12A0, 4'b0000, 4'b0000, 0, 2, 2, 7, 4'b1011, 7'b1110111, 0));
      vecs.push_back(mk("pwm2_off", 16'h12A0, 4'b0000, 4'b0000, 0, 2, 2, 8, 4'b1111, 7'b0000000, 0));
      vecs.push_back(mk("pwm0",    16'h12A0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b1111, 7'b0000000, 0));

      // Reset values while held in reset.
      #12;
      check("rst_grounds", 32'(grounds), 32'hF);
      check("rst_display", 32'(display), 32'h0);
      check("rst_dp", 32'(dp), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      do_reset();

      foreach (vecs[k]) begin
         apply_load(vecs[k].data, vecs[k].dpv, vecs[k].blank, vecs[k].lz, vecs[k].bright);
         wait_slot(vecs[k].digit, vecs[k].presc);
         check({vecs[k].name, "_grounds"}, 32'(grounds), 32'(vecs[k].exp_g));
         check({vecs[k].name, "_display"}, 32'(display), 32'(vecs[k].exp_seg));
         check({vecs[k].name, "_dp"}, 32'(dp), 32'(vecs[k].exp_dp));
      end

      // frame_done: single-cycle pulse on the wrap edge, exactly 64 clocks apart.
      apply_load(16'h12A0, 4'b0000, 4'b0000, 1'b0, 2'd3);
      last_pulse = -1;
      pulses     = 0;
      for (int n = 0; n < 200; n++) begin
         step();
         if (frame_done) begin
            check("frame_done_phase", 32'((cyc - 1) % 64), 32'd63);
            if (last_pulse >= 0) check("frame_done_spacing", 32'(cyc - last_pulse), 32'd64);
            last_pulse = cyc;
            pulses++;
         end
      end
      check("frame_done_count", 32'(pulses >= 3), 32'd1);

      // PWM duty: brightness 1 lights one slot for 4 of its 16 clocks.
      apply_load(16'h12A0, 4'b0000, 4'b0000, 1'b0, 2'd1);
      wait_slot(1, 15);
      lit_cnt = 0;
      for (int n = 0; n < 16; n++) begin
         step();
         if (grounds != 4'hF) lit_cnt++;
      end
      check("pwm1_lit_clocks", 32'(lit_cnt), 32'd4);

      brightness = 2'd0;
      step();
      lit_cnt = 0;
      for (int n = 0; n < 64; n++) begin
         step();
         if (grounds != 4'hF) lit_cnt++;
      end
      check("pwm0_lit_clocks", 32'(lit_cnt), 32'd0);

      // Live datain without load is ignored.
      apply_load(16'h12A0, 4'b0000, 4'b0000, 1'b0, 2'd3);
      datain = 16'hFFFF;
      wait_slot(0, 8);
      check("live_ignored", 32'(display), 32'(7'b0000110));

      // Load coinciding with tick: new idx and new data appear together one edge later.
      wait_slot(0, 14);
      datain = 16'h9876;
      load   = 1'b1;
      step();
      load   = 1'b0;
      check("collide_old_grounds", 32'(grounds), 32'hE);
      check("collide_old_display", 32'(display), 32'(7'b0000110));
      step();
      check("collide_new_grounds", 32'(grounds), 32'hD);
      check("collide_new_display", 32'(display), 32'(7'b1111111));

      // Mid-scan asynchronous reset while digit 2 is lit.
      wait_slot(2, 5);
      check("pre_reset_grounds", 32'(grounds), 32'hB);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_grounds", 32'(grounds), 32'hF);
      check("async_rst_display", 32'(display), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc     = 0;
      step();
      check("restart_grounds", 32'(grounds), 32'hE);
      check("restart_display", 32'(display), 32'(7'b0111111));
      wait_slot(1, 0);
      check("restart_next_digit", 32'(grounds), 32'hD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
